machine_timer: RTL and testbench

// Memory-mapped RV32 machine timer (mtime/mtimecmp) that drives the CPU interrupt input.
// It sits on the data-memory side of the core, decoded alongside data memory by a chip select.
// It owns a 64-bit free-running counter, a 64-bit compare register, a prescaler, and a sticky

---
 rtl/machine_timer.sv | 84 ++++++++
 tb/tb_machine_timer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/machine_timer.sv
// machine_timer: RV32 mtime/mtimecmp timer with prescaler, sticky pending, IRQ out (ports: I_clk, I_rst, I_sel, I_memrw, I_address, I_data -> O_data, O_interrupt)
module machine_timer #(
  parameter int          PRESCALE    = 1,
  parameter logic [31:0] BASE_OFFSET = 32'h0000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_sel,
  input  logic        I_memrw,
  input  logic [31:0] I_address,
  input  logic [31:0] I_data,
  output logic [31:0] O_data,
  output logic        O_interrupt
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  logic [31:0] off;
  logic [2:0] idx;
  logic wr, tick, match, unused_bits;
  logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
  logic [CW-1:0] pre_q, pre_d;
  logic count_en_q, count_en_d, irq_en_q, irq_en_d, pending_q, pending_d, irq_q, irq_d;
  logic [31:0] rd;
  always_comb begin
    off = I_address - BASE_OFFSET;
    idx = off[4:2];
    unused_bits = ^{off[31:5], off[1:0]};
    wr = I_sel & I_memrw;
    tick = count_en_q && pre_q == LAST;
    match = mtime_q >= cmp_q;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    pre_d = count_en_q ? (tick ? '0 : pre_q + CW'(1)) : pre_q;
    cmp_d = cmp_q;
    count_en_d = count_en_q;
    irq_en_d = irq_en_q;
    pending_d = match | (pending_q & ~(wr && idx == 3'd5 && I_data[0]));
    if (wr)
      case (idx)
        3'd0: begin
          mtime_d = {mtime_q[63:32], I_data};
          pre_d = '0;
        end
        3'd1: begin
          mtime_d = {I_data, mtime_q[31:0]};
          pre_d = '0;
        end
        3'd2: cmp_d[31:0] = I_data;
        3'd3: cmp_d[63:32] = I_data;
        3'd4: begin
          count_en_d = I_data[0];
          irq_en_d = I_data[1];
        end
        default: ;
      endcase
    irq_d = pending_d & irq_en_d;
    rd = idx == 3'd0 ? mtime_q[31:0] :
         idx == 3'd1 ? mtime_q[63:32] :
         idx == 3'd2 ? cmp_q[31:0] :
         idx == 3'd3 ? cmp_q[63:32] :
         idx == 3'd4 ? {30'b0, irq_en_q, count_en_q} :
         idx == 3'd5 ? {31'b0, pending_q} : 32'b0;
    O_data = I_sel ? rd : 32'b0;
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      mtime_q <= '0;
      cmp_q <= '1;
      pre_q <= '0;
      count_en_q <= 1'b0;
      irq_en_q <= 1'b0;
      pending_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q <= cmp_d;
      pre_q <= pre_d;
      count_en_q <= count_en_d;
      irq_en_q <= irq_en_d;
      pending_q <= pending_d;
      irq_q <= irq_d;
    end
  end
  assign O_interrupt = irq_q;
endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: directed and random checks of two machine_timer instances (PRESCALE 1 and 4) against a cycle-count model
module tb_machine_timer;
  logic clk = 1'b0;
  logic rst = 1'b1, sel = 1'b0, memrw = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rd0, rd1;
  logic irq0, irq1;
  int n_chk = 0, n_err = 0;
  int P[2] = '{1, 4};
  logic [63:0] m_base[2] = '{64'd0, 64'd0};
  logic [63:0] m_cmp[2] = '{64'd0, 64'd0};
  longint m_enc[2] = '{0, 0};
  bit m_en[2], m_ie[2], m_pend[2], m_irq[2];

  machine_timer #(.PRESCALE(1)) dut0 (.I_clk(clk), .I_rst(rst), .I_sel(sel), .I_memrw(memrw),
    .I_address(addr), .I_data(wdata), .O_data(rd0), .O_interrupt(irq0));
  machine_timer #(.PRESCALE(4)) dut1 (.I_clk(clk), .I_rst(rst), .I_sel(sel), .I_memrw(memrw),
    .I_address(addr), .I_data(wdata), .O_data(rd1), .O_interrupt(irq1));

  always #50 clk = ~clk;

  function automatic logic [63:0] mt(int i);
    return m_base[i] + 64'(m_enc[i] / longint'(P[i]));
  endfunction

  function automatic logic [31:0] exp_rd(int i);
    logic [63:0] t;
    t = mt(i);
    if (!sel) return 32'd0;
    case (addr[4:2])
      3'd0: return t[31:0];
      3'd1: return t[63:32];
      3'd2: return m_cmp[i][31:0];
      3'd3: return m_cmp[i][63:32];
      3'd4: return {30'd0, m_ie[i], m_en[i]};
      3'd5: return {31'd0, m_pend[i]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      logic [63:0] cur;
      bit match, w, en_old;
      cur = mt(i);
      match = cur >= m_cmp[i];
      w = sel && memrw;
      en_old = m_en[i];
      if (rst) begin
        m_base[i] = '0; m_enc[i] = 0; m_cmp[i] = '1;
        m_en[i] = 0; m_ie[i] = 0; m_pend[i] = 0; m_irq[i] = 0;
      end else begin
        m_pend[i] = match || (m_pend[i] && !(w && addr[4:2] == 3'd5 && wdata[0]));
        if (en_old) m_enc[i]++;
        if (w)
          case (addr[4:2])
            3'd0: begin m_base[i] = {cur[63:32], wdata}; m_enc[i] = 0; end
            3'd1: begin m_base[i] = {wdata, cur[31:0]}; m_enc[i] = 0; end
            3'd2: m_cmp[i][31:0] = wdata;
            3'd3: m_cmp[i][63:32] = wdata;
            3'd4: begin m_en[i] = wdata[0]; m_ie[i] = wdata[1]; end
            default: ;
          endcase
        m_irq[i] = m_pend[i] && m_ie[i];
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("irq0", {31'd0, irq0}, {31'd0, m_irq[0]});
    check("irq1", {31'd0, irq1}, {31'd0, m_irq[1]});
  endtask

  task automatic idle(int n);
    sel = 0; memrw = 0;
    repeat (n) step();
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    sel = 1; memrw = 1; addr = a; wdata = d;
    step();
    sel = 0; memrw = 0;
  endtask

  task automatic rd(logic [31:0] a);
    sel = 1; memrw = 0; addr = a;
    #1;
    check($sformatf("rd0@%h", a), rd0, exp_rd(0));
    check($sformatf("rd1@%h", a), rd1, exp_rd(1));
  endtask

  task automatic rdc(logic [31:0] a, logic [31:0] e);
    rd(a);
    check($sformatf("reset0@%h", a), rd0, e);
    check($sformatf("reset1@%h", a), rd1, e);
  endtask

  initial begin
    int t;
    step();
    step();
    rst = 0;
    rdc(32'h00, 32'h0);
    rdc(32'h04, 32'h0);
    rdc(32'h08, 32'hFFFF_FFFF);
    rdc(32'h0C, 32'hFFFF_FFFF);
    rdc(32'h10, 32'h0);
    rdc(32'h14, 32'h0);
    rdc(32'h18, 32'h0);
    wr(32'h10, 32'h1);
    idle(10);
    rd(32'h00);
    check("t2_lo_p1", rd0, 32'd10);
    check("t2_lo_p4", rd1, 32'd2);
    wr(32'h10, 32'h0);
    idle(5);
    rd(32'h00);
    check("t2_frozen_p1", rd0, 32'd11);
    check("t2_frozen_p4", rd1, 32'd2);
    wr(32'h00, 32'hFFFF_FFFE);
    wr(32'h04, 32'h0);
    wr(32'h10, 32'h1);
    idle(2);
    rd(32'h00);
    check("t3_lo_p1", rd0, 32'd0);
    rd(32'h04);
    check("t3_hi_p1", rd0, 32'd1);
    idle(6);
    rd(32'h00);
    check("t3_lo_p4", rd1, 32'd0);
    rd(32'h04);
    check("t3_hi_p4", rd1, 32'd1);
    wr(32'h10, 32'h0);
    wr(32'h00, 32'h0);
    wr(32'h04, 32'h0);
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'h5);
    wr(32'h10, 32'h3);
    t = 0;
    while (!irq0 && t < 20) begin
      step();
      t++;
    end
    check("t4_rise_cycles", 32'(t), 32'd6);
    rd(32'h00);
    check("t4_mtime_at_irq", rd0, 32'd6);
    wr(32'h14, 32'h1);
    rd(32'h14);
    check("t4_w1c_match_keeps", rd0, 32'd1);
    check("t4_irq_still", {31'd0, irq0}, 32'd1);
    wr(32'h10, 32'h1);
    check("t4_ie_off_irq", {31'd0, irq0}, 32'd0);
    rd(32'h14);
    check("t4_ie_off_pend", rd0, 32'd1);
    wr(32'h10, 32'h3);
    check("t4_ie_on_irq", {31'd0, irq0}, 32'd1);
    wr(32'h08, 32'd100);
    wr(32'h14, 32'h1);
    check("t4_cleared_irq", {31'd0, irq0}, 32'd0);
    rd(32'h14);
    check("t4_cleared_pend", rd0, 32'd0);
    wr(32'h00, 32'h40);
    rd(32'h00);
    check("t5_write_wins", rd0, 32'h40);
    check("t5_write_wins_p4", rd1, 32'h40);
    step();
    rd(32'h00);
    check("t5_next_p1", rd0, 32'h41);
    idle(2);
    rd(32'h00);
    check("t5_hold_p4", rd1, 32'h40);
    idle(1);
    rd(32'h00);
    check("t5_next_p4", rd1, 32'h41);
    wr(32'h00, 32'h0);
    wr(32'h04, 32'h0);
    idle(9);
    rd(32'h00);
    check("t6_p4_count", rd1, 32'd2);
    wr(32'h08, 32'h1);
    idle(2);
    check("t6_irq_p1", {31'd0, irq0}, 32'd1);
    check("t6_irq_p4", {31'd0, irq1}, 32'd1);
    rst = 1; sel = 1; memrw = 1; addr = 32'h10; wdata = 32'h3;
    step();
    rst = 0; sel = 0; memrw = 0;
    check("t6_rst_irq_p1", {31'd0, irq0}, 32'd0);
    check("t6_rst_irq_p4", {31'd0, irq1}, 32'd0);
    rdc(32'h00, 32'h0);
    rdc(32'h08, 32'hFFFF_FFFF);
    rdc(32'h10, 32'h0);
    rdc(32'h14, 32'h0);
    for (int k = 0; k < 600; k++) begin
      rst = $urandom_range(0, 99) == 0;
      sel = $urandom_range(0, 1);
      memrw = $urandom_range(0, 2) == 0;
      addr = $urandom;
      wdata = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 40);
      #1;
      check("rand_rd0", rd0, exp_rd(0));
      check("rand_rd1", rd1, exp_rd(1));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
